// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the mdu_iter multiply/divide unit: op encodings,
// FSM state encoding and small op-classification helpers.
package mdu_iter_pkg;

  localparam int MDU_OP_W = 3;

  typedef enum logic [MDU_OP_W-1:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } mdu_state_e;

  function automatic logic is_div_op(input logic [MDU_OP_W-1:0] op);
    return (op[2:1] == 2'b01);
  endfunction

  // Even encodings are the signed flavours: MULT, DIV, MADD, MSUB.
  function automatic logic is_signed_op(input logic [MDU_OP_W-1:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_acc_op(input logic [MDU_OP_W-1:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response bundle between the EX stage (master) and mdu_iter (slave).
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  import mdu_iter_pkg::*;

  logic                  start;
  logic [MDU_OP_W-1:0]   op;
  logic [WIDTH-1:0]      a;
  logic [WIDTH-1:0]      b;
  logic [2*WIDTH-1:0]    hilo_in;
  logic                  cancel;
  logic                  busy;
  logic                  hilo_we;
  logic [2*WIDTH-1:0]    hilo_out;
  logic                  div_by_zero;

  modport master (
    output start, op, a, b, hilo_in, cancel,
    input  busy, hilo_we, hilo_out, div_by_zero
  );

  modport slave (
    input  start, op, a, b, hilo_in, cancel,
    output busy, hilo_we, hilo_out, div_by_zero
  );

endinterface

// File: rtl/mdu_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// The first iteration is folded into the load cycle; done marks the final iteration.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             running_q;
  logic [WIDTH-1:0] div_q, rem_q, quo_q;
  logic [WIDTH-1:0] src_rem, src_quo, src_div;
  logic [WIDTH:0]   partial, diff;
  logic [WIDTH-1:0] rem_d, quo_d;

  // NOTE: every output of this always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    src_div = start ? divisor : div_q;
    partial = {src_rem, src_quo[WIDTH-1]};
    diff    = partial - {1'b0, src_div};
    // A borrow out of the trial subtraction restores the partial remainder.
    if (diff[WIDTH]) begin
      rem_d = partial[WIDTH-1:0];
      quo_d = {src_quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_d = diff[WIDTH-1:0];
      quo_d = {src_quo[WIDTH-2:0], 1'b1};
    end
  end

  assign done = running_q && (cnt_q == CNT_LAST);

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      running_q <= 1'b0;
      div_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
    end else if (start) begin
      cnt_q     <= CNT_W'(1);
      running_q <= 1'b1;
      div_q     <= divisor;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
    end else if (running_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      if (done) begin
        cnt_q     <= '0;
        running_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit producing {HI,LO} for the EX stage.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops (op 4..7).
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  mdu_iter_if.slave  io
);

  localparam int DW    = 2 * WIDTH;
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

  mdu_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MDU_OP_W-1:0] op_q;
  logic [WIDTH-1:0]    a_q, b_q;
  logic [DW-1:0]       hilo_out_q;
  logic                hilo_we_q, dz_q;

  logic                write_en, write_dz;
  logic [DW-1:0]       write_val;
  logic                op_ok, accept;
  logic [DW-1:0]       ext_a, ext_b, prod_in, mul_tap, mul_result;
  logic                div_start, div_done;
  logic [WIDTH-1:0]    div_dividend, div_divisor, div_quo, div_rem;
  logic [WIDTH-1:0]    quo_fix, rem_fix;

`ifdef MDU_MADD_EN
  logic [DW-1:0]       hilo_q;
  assign op_ok = 1'b1;
`else
  // Accumulate encodings fall through as a one-cycle NOP.
  assign op_ok = ~is_acc_op(io.op);
`endif

  assign accept = (state_q == S_IDLE) && io.start && !io.cancel && op_ok;

  // The product is formed from the live operands in the start cycle and then delayed.
  assign ext_a   = is_signed_op(io.op) ? {{WIDTH{io.a[WIDTH-1]}}, io.a} : {{WIDTH{1'b0}}, io.a};
  assign ext_b   = is_signed_op(io.op) ? {{WIDTH{io.b[WIDTH-1]}}, io.b} : {{WIDTH{1'b0}}, io.b};
  assign prod_in = ext_a * ext_b;

  if (MUL_CYCLES == 1) begin : g_mul_direct
    assign mul_tap = prod_in;
  end else begin : g_mul_pipe
    logic [DW-1:0] pipe_q [MUL_CYCLES-1];
    // NOTE: the delay line holds data only and is left unreset; hilo_we alone qualifies it.
    always_ff @(posedge clk) begin
      pipe_q[0] <= prod_in;
      for (int i = 1; i < MUL_CYCLES - 1; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign mul_tap = pipe_q[MUL_CYCLES-2];
  end

`ifdef MDU_MADD_EN
  logic [MDU_OP_W-1:0] acc_op;
  logic [DW-1:0]       acc_base;
  // With a single-cycle multiply the result is written from the start cycle itself.
  assign acc_op   = (MUL_CYCLES == 1) ? io.op : op_q;
  assign acc_base = (MUL_CYCLES == 1) ? io.hilo_in : hilo_q;

  always_comb begin
    mul_result = mul_tap;
    if (is_acc_op(acc_op)) mul_result = acc_op[1] ? (acc_base - mul_tap) : (acc_base + mul_tap);
  end
`else
  assign mul_result = mul_tap;
`endif

  // Divider runs on magnitudes; signs are restored in FIX.
  assign div_dividend = (is_signed_op(io.op) && io.a[WIDTH-1]) ? -io.a : io.a;
  assign div_divisor  = (is_signed_op(io.op) && io.b[WIDTH-1]) ? -io.b : io.b;
  assign div_start    = accept && is_div_op(io.op);

  mdu_div_core #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign quo_fix = (is_signed_op(op_q) && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -div_quo : div_quo;
  assign rem_fix = (is_signed_op(op_q) && a_q[WIDTH-1]) ? -div_rem : div_rem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_en  = 1'b0;
    write_dz  = 1'b0;
    write_val = mul_result;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_div_op(io.op)) begin
            state_d = S_DIV;
          end else if (MUL_CYCLES == 1) begin
            write_en = 1'b1;
          end else begin
            state_d = S_MUL;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      S_MUL: begin
        if (io.cancel) begin
          state_d = S_IDLE;
        end else if (cnt_q == MUL_LAST) begin
          write_en = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DIV: begin
        if (io.cancel)    state_d = S_IDLE;
        else if (div_done) state_d = S_FIX;
      end
      S_FIX: begin
        if (io.cancel) begin
          state_d = S_IDLE;
        end else begin
          write_en = 1'b1;
          state_d  = S_IDLE;
          // Divide by zero reports HI=a, LO=all ones instead of the raw divider output.
          if (b_q == '0) begin
            write_val = {a_q, {WIDTH{1'b1}}};
            write_dz  = 1'b1;
          end else begin
            write_val = {rem_fix, quo_fix};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      hilo_out_q <= '0;
      hilo_we_q  <= 1'b0;
      dz_q       <= 1'b0;
`ifdef MDU_MADD_EN
      hilo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hilo_we_q <= write_en;
      dz_q      <= write_dz;
      if (write_en) hilo_out_q <= write_val;
      if (accept) begin
        op_q <= io.op;
        a_q  <= io.a;
        b_q  <= io.b;
`ifdef MDU_MADD_EN
        hilo_q <= io.hilo_in;
`endif
      end
    end
  end

  assign io.busy        = (state_q != S_IDLE);
  assign io.hilo_we     = hilo_we_q;
  assign io.hilo_out    = hilo_out_q;
  assign io.div_by_zero = dz_q;

endmodule
